// File: rtl/round_robin_arbiter_with_hold.sv
`default_nettype none
// ============================================================================
//  Module   : round_robin_arbiter_with_hold
//  Purpose  : Round-robin arbiter for N level-sensitive requesters. A granted
//             requester keeps the resource for as long as it holds its
//             request high. On release, the grant passes directly to the next
//             pending requester in circular order, starting after the owner,
//             with no idle cycle in between. The owner itself can only be
//             granted again after passing through IDLE.
//
//             Optional hold limit: define ARB_HOLD_LIMIT_EN to enable it.
//             With the limit enabled, an owner that has held the grant for
//             MAX_HOLD cycles is preempted when another requester is waiting.
//             With the limit disabled, the hold counter is not built and
//             preempt is tied low.
//
//  Ports    : clk       - sole clock; all state updates on the rising edge
//             rst       - asynchronous reset, active low (0 = in reset)
//             requests  - [N] per-requester request, held high while in use
//             grants    - [N] registered grant vector, one-hot or zero
//             busy      - registered, 1 whenever grants != 0
//             owner_id  - [$clog2(N)] registered index of the owner; 0 when
//                         idle
//             preempt   - registered one-cycle pulse on a forced handover
//
//  Revision : 1.0 - initial release
// ============================================================================
module round_robin_arbiter_with_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         requests,
  output logic [N-1:0]         grants,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner_id,
  output logic                 preempt
);

  localparam int ID_W = $clog2(N);
  localparam logic [N-1:0] c_one = N'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_grants;
  logic [ID_W-1:0] r_owner_id;
  logic [ID_W-1:0] r_last_owner;
  logic            r_busy;
  logic            r_preempt;

  logic [N-1:0]    w_cand;
  logic            w_found;
  logic [ID_W-1:0] w_pick;
  logic [N-1:0]    w_pick_onehot;
  logic            w_owner_req;
  logic            w_hold_expired;

  // Candidates exclude the current owner. In IDLE r_grants is zero, so the
  // mask covers every requester. On a release the owner's bit is already
  // low, so it cannot be re-granted without first going through IDLE.
  assign w_cand      = requests & ~r_grants;
  assign w_owner_req = |(requests & r_grants);

  // Circular search that starts one position after last_owner. last_owner
  // always equals the current owner while OWNED, so the same search serves
  // both the idle grant and the handover cases.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_last_owner) + k) % N;
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(idx);
      end
    end
  end

  assign w_pick_onehot = c_one << w_pick;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] r_hold_cnt;
  assign w_hold_expired = (r_hold_cnt == CNT_W'(MAX_HOLD));
`else
  assign w_hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grants     <= '0;
      r_owner_id   <= '0;
      r_last_owner <= ID_W'(N - 1);
      r_busy       <= 1'b0;
      r_preempt    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      r_hold_cnt   <= '0;
`endif
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state      <= ST_OWNED;
            r_grants     <= w_pick_onehot;
            r_owner_id   <= w_pick;
            r_last_owner <= w_pick;
            r_busy       <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt   <= CNT_W'(1);
`endif
          end
        end

        ST_OWNED: begin
          if (!w_owner_req) begin
            if (w_found) begin
              // Release with others waiting: hand over on this same edge.
              r_grants     <= w_pick_onehot;
              r_owner_id   <= w_pick;
              r_last_owner <= w_pick;
`ifdef ARB_HOLD_LIMIT_EN
              r_hold_cnt   <= CNT_W'(1);
`endif
            end else begin
              // last_owner is kept so the next search starts after it.
              r_state    <= ST_IDLE;
              r_grants   <= '0;
              r_owner_id <= '0;
              r_busy     <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
              r_hold_cnt <= '0;
`endif
            end
          end else if (w_hold_expired && w_found) begin
            // Forced handover. The preempted owner keeps requesting and
            // competes again in normal round-robin order.
            r_grants     <= w_pick_onehot;
            r_owner_id   <= w_pick;
            r_last_owner <= w_pick;
            r_preempt    <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt   <= CNT_W'(1);
`endif
          end else begin
`ifdef ARB_HOLD_LIMIT_EN
            if (!w_hold_expired) begin
              r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
`endif
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_grants <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign grants   = r_grants;
  assign busy     = r_busy;
  assign owner_id = r_owner_id;
  assign preempt  = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter_with_hold.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_robin_arbiter_with_hold
//  Purpose  : Directed bench for round_robin_arbiter_with_hold (N=4,
//             MAX_HOLD=4). The driver applies one request vector per cycle
//             and queues the hand-computed outputs expected after the next
//             rising edge. An independent monitor pops one entry after every
//             rising edge and compares it with the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter_with_hold;

  logic       clk;
  logic       rst;
  logic [3:0] requests;
  logic [3:0] grants;
  logic       busy;
  logic [1:0] owner_id;
  logic       preempt;

  // {grants, owner_id, busy, preempt}
  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_fails;
  int         vec_no;

  round_robin_arbiter_with_hold #(
    .N        (4),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .requests (requests),
    .grants   (grants),
    .busy     (busy),
    .owner_id (owner_id),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each queued entry describes the outputs after the next edge.
  always @(posedge clk) begin
    logic [7:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({grants, owner_id, busy, preempt} !== e) begin
        n_fails++;
        $display("FAIL vec%0d: grants=%b id=%0d busy=%b preempt=%b, required grants=%b id=%0d busy=%b preempt=%b",
                 vec_no, grants, owner_id, busy, preempt, e[7:4], e[3:2], e[1], e[0]);
      end
      vec_no++;
    end
  end

  task automatic v(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                   input logic b, input logic p);
    @(negedge clk);
    requests = r;
    exp_q.push_back({g, id, b, p});
  endtask

  task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    vec_no   = 0;
    rst      = 1'b0;
    requests = 4'b0000;
    repeat (3) @(negedge clk);
    check_now("reset_state", {grants, owner_id, busy, preempt}, 8'b0);
    rst = 1'b1;

    // First grant, then same-edge handover, then idle.
    v(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    v(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    v(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Full rotation 0,1,2,3,0 from last_owner=3, no idle cycles.
    v(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    v(4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    v(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
    v(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
    v(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    v(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    v(4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Lone requester 0 re-granted only after an idle cycle (search wraps).
    v(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold limit: owner 0 holds 4 cycles, requester 2 waiting from cycle 3.
    v(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
    v(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1);
    v(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
`else
    v(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
`endif
    v(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    v(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Saturated counter with nobody else waiting: owner keeps the grant.
    for (int i = 0; i < 7; i++) v(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    v(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an ownership.
    v(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_now("async_reset", {grants, owner_id, busy, preempt}, 8'b0);
    @(negedge clk);
    check_now("reset_held", {grants, owner_id, busy, preempt}, 8'b0);
    rst = 1'b1;
    v(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
    v(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_fails++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
